// File: rtl/fifo_buffer.sv
// Synchronous FIFO with registered read data, occupancy count, programmable
// almost-full/almost-empty thresholds and a sticky overflow/underflow flag.
module fifo_buffer #(
  parameter int DATA_WIDTH = 6,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  init,
  input  logic [ADDR_WIDTH:0]   umbral_alto,
  input  logic [ADDR_WIDTH:0]   umbral_bajo,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   count
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0]         DEPTH_C   = CW'(DEPTH);
  localparam logic [CW-1:0]         ALTO_RST  = CW'(DEPTH - 1);
  localparam logic [CW-1:0]         BAJO_RST  = CW'(1);
  localparam logic [CW-1:0]         CNT_ONE   = CW'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = ADDR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_r;
  logic [ADDR_WIDTH-1:0] rd_ptr_r;
  logic [CW-1:0]         count_r;
  logic [CW-1:0]         alto_r;
  logic [CW-1:0]         bajo_r;
  logic [DATA_WIDTH-1:0] data_out_r;
  logic                  valid_out_r;
  logic                  error_r;
  logic                  wr_en_s;
  logic                  rd_en_s;

  // Accept decisions: a pop frees a slot, so a full FIFO still takes a push alongside it.
  always_comb begin
    rd_en_s = 1'b0;
    wr_en_s = 1'b0;
    if (pop && (count_r != '0)) begin
      rd_en_s = 1'b1;
    end else begin
      rd_en_s = 1'b0;
    end
    if (push && ((count_r != DEPTH_C) || rd_en_s)) begin
      wr_en_s = 1'b1;
    end else begin
      wr_en_s = 1'b0;
    end
  end

  // Storage array; contents are don't-care after reset so it carries no reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r] <= data_in;
    end
  end

  // Pointers, occupancy, read data, thresholds and sticky error.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      count_r     <= '0;
      data_out_r  <= '0;
      valid_out_r <= 1'b0;
      error_r     <= 1'b0;
      alto_r      <= ALTO_RST;
      bajo_r      <= BAJO_RST;
    end else begin
      if (init) begin
        alto_r <= umbral_alto;
        bajo_r <= umbral_bajo;
      end
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (rd_en_s) begin
        data_out_r  <= mem_r[rd_ptr_r];
        rd_ptr_r    <= rd_ptr_r + PTR_ONE;
        valid_out_r <= 1'b1;
      end else begin
        valid_out_r <= 1'b0;
      end
      case ({wr_en_s, rd_en_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
      if ((push && !wr_en_s) || (pop && !rd_en_s)) begin
        error_r <= 1'b1;
      end
    end
  end

  assign data_out     = data_out_r;
  assign valid_out    = valid_out_r;
  assign error        = error_r;
  assign count        = count_r;
  assign empty        = (count_r == '0);
  assign full         = (count_r == DEPTH_C);
  assign almost_full  = (count_r >= alto_r);
  assign almost_empty = (count_r <= bajo_r);

endmodule

// File: tb/tb_fifo_buffer.sv
// Self-checking bench for fifo_buffer: directed scenarios plus randomized
// traffic compared against a queue-based reference model.
module tb_fifo_buffer;

  logic       clk = 1'b0;
  logic       reset, init, push, pop;
  logic [3:0] umbral_alto, umbral_bajo, count;
  logic [5:0] data_in, data_out;
  logic       valid_out, empty, full, almost_full, almost_empty, error;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [5:0] mq[$];
  int         m_alto, m_bajo;
  logic       m_err, m_valid;
  logic [5:0] m_dout;

  fifo_buffer #(.DATA_WIDTH(6), .DEPTH(8), .ADDR_WIDTH(3)) dut (
    .clk(clk), .reset(reset), .init(init),
    .umbral_alto(umbral_alto), .umbral_bajo(umbral_bajo),
    .push(push), .data_in(data_in), .pop(pop),
    .data_out(data_out), .valid_out(valid_out), .empty(empty), .full(full),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .error(error), .count(count)
  );

  always #5 clk = ~clk;

  task automatic model_edge();
    bit rd, wr;
    if (reset) begin
      mq.delete();
      m_alto = 7; m_bajo = 1; m_err = 1'b0; m_dout = 6'd0; m_valid = 1'b0;
    end else begin
      rd = pop && (mq.size() > 0);
      wr = push && ((mq.size() < 8) || rd);
      if (init) begin
        m_alto = int'(umbral_alto);
        m_bajo = int'(umbral_bajo);
      end
      if ((push && !wr) || (pop && !rd)) m_err = 1'b1;
      if (rd) begin
        m_dout = mq.pop_front();
        m_valid = 1'b1;
      end else begin
        m_valid = 1'b0;
      end
      if (wr) mq.push_back(data_in);
    end
  endtask

  task automatic tick(input logic p, input logic q, input logic [5:0] d);
    push = p; pop = q; data_in = d;
    @(posedge clk);
    model_edge();
    #1;
    push = 1'b0; pop = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(1'b1, 1'b1, 6'h2A);
    tick(1'b1, 1'b1, 6'h15);
    reset = 1'b0;
    n_checks++; if (count !== 4'd0) begin n_errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    n_checks++; if (empty !== 1'b1) begin n_errors++; $display("FAIL reset_empty: got %0b expected 1", empty); end
    n_checks++; if (almost_empty !== 1'b1) begin n_errors++; $display("FAIL reset_almost_empty: got %0b expected 1", almost_empty); end
    n_checks++; if (full !== 1'b0 || almost_full !== 1'b0) begin n_errors++; $display("FAIL reset_full_flags: got %0b%0b expected 00", full, almost_full); end
    n_checks++; if (valid_out !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %0b expected 0", valid_out); end
    n_checks++; if (error !== 1'b0) begin n_errors++; $display("FAIL reset_error: got %0b expected 0", error); end
    n_checks++; if (data_out !== 6'h00) begin n_errors++; $display("FAIL reset_data_out: got %0h expected 0", data_out); end
  endtask

  task automatic test_fill_drain();
    init = 1'b1; umbral_alto = 4'd6; umbral_bajo = 4'd2;
    tick(1'b0, 1'b0, 6'h00);
    init = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick(1'b1, 1'b0, 6'(i));
      n_checks++; if (count !== 4'(i)) begin n_errors++; $display("FAIL fill_count: got %0d expected %0d", count, i); end
      n_checks++; if (almost_full !== (i >= 6)) begin n_errors++; $display("FAIL fill_almost_full at %0d: got %0b", i, almost_full); end
      n_checks++; if (full !== (i == 8)) begin n_errors++; $display("FAIL fill_full at %0d: got %0b", i, full); end
    end
    for (int i = 1; i <= 8; i++) begin
      tick(1'b0, 1'b1, 6'h00);
      n_checks++; if (data_out !== 6'(i) || valid_out !== 1'b1) begin n_errors++; $display("FAIL drain_data: got %0h/%0b expected %0h/1", data_out, valid_out, i); end
      n_checks++; if (almost_empty !== ((8 - i) <= 2)) begin n_errors++; $display("FAIL drain_almost_empty at count %0d: got %0b", 8 - i, almost_empty); end
      n_checks++; if (empty !== (i == 8)) begin n_errors++; $display("FAIL drain_empty at count %0d: got %0b", 8 - i, empty); end
    end
    tick(1'b0, 1'b0, 6'h00);
    n_checks++; if (valid_out !== 1'b0 || error !== 1'b0) begin n_errors++; $display("FAIL drain_idle: got valid %0b error %0b expected 0 0", valid_out, error); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 8; i++) tick(1'b1, 1'b0, 6'h10 + 6'(i));
    tick(1'b1, 1'b0, 6'h3F);
    n_checks++; if (count !== 4'd8) begin n_errors++; $display("FAIL overflow_count: got %0d expected 8", count); end
    n_checks++; if (error !== 1'b1) begin n_errors++; $display("FAIL overflow_error: got %0b expected 1", error); end
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, 1'b1, 6'h00);
      n_checks++; if (data_out !== 6'h10 + 6'(i)) begin n_errors++; $display("FAIL overflow_data: got %0h expected %0h", data_out, 6'h10 + 6'(i)); end
    end
    n_checks++; if (error !== 1'b1) begin n_errors++; $display("FAIL overflow_sticky: got %0b expected 1", error); end
    reset = 1'b1; tick(1'b0, 1'b0, 6'h00); reset = 1'b0;
    n_checks++; if (error !== 1'b0) begin n_errors++; $display("FAIL error_clear: got %0b expected 0", error); end
  endtask

  task automatic test_underflow_simul();
    tick(1'b1, 1'b1, 6'h15);
    n_checks++; if (count !== 4'd1) begin n_errors++; $display("FAIL underflow_count: got %0d expected 1", count); end
    n_checks++; if (valid_out !== 1'b0) begin n_errors++; $display("FAIL underflow_valid: got %0b expected 0", valid_out); end
    n_checks++; if (error !== 1'b1) begin n_errors++; $display("FAIL underflow_error: got %0b expected 1", error); end
    tick(1'b0, 1'b1, 6'h00);
    n_checks++; if (data_out !== 6'h15 || valid_out !== 1'b1) begin n_errors++; $display("FAIL underflow_read: got %0h/%0b expected 15/1", data_out, valid_out); end
    reset = 1'b1; tick(1'b0, 1'b0, 6'h00); reset = 1'b0;
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < 8; i++) tick(1'b1, 1'b0, 6'h20 + 6'(i));
    tick(1'b1, 1'b1, 6'h2A);
    n_checks++; if (count !== 4'd8 || error !== 1'b0) begin n_errors++; $display("FAIL fullpp_state: got count %0d error %0b expected 8 0", count, error); end
    n_checks++; if (data_out !== 6'h20) begin n_errors++; $display("FAIL fullpp_oldest: got %0h expected 20", data_out); end
    for (int i = 1; i <= 8; i++) begin
      tick(1'b0, 1'b1, 6'h00);
      n_checks++; if (data_out !== ((i == 8) ? 6'h2A : 6'h20 + 6'(i))) begin n_errors++; $display("FAIL fullpp_wrap pop %0d: got %0h", i, data_out); end
    end
    n_checks++; if (empty !== 1'b1) begin n_errors++; $display("FAIL fullpp_empty: got %0b expected 1", empty); end
  endtask

  task automatic test_threshold_reset();
    // thresholds are 7/1 after the earlier reset
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, 6'(i));
    umbral_alto = 4'd2; init = 1'b0;
    tick(1'b0, 1'b0, 6'h00);
    n_checks++; if (almost_full !== 1'b0) begin n_errors++; $display("FAIL hold_almost_full: got %0b expected 0", almost_full); end
    reset = 1'b1; tick(1'b0, 1'b0, 6'h00); reset = 1'b0;
    n_checks++; if (count !== 4'd0 || empty !== 1'b1) begin n_errors++; $display("FAIL midreset_count: got %0d expected 0", count); end
    for (int i = 1; i <= 7; i++) begin
      tick(1'b1, 1'b0, 6'(i));
      n_checks++; if (almost_full !== (i >= 7)) begin n_errors++; $display("FAIL midreset_alto at %0d: got %0b", i, almost_full); end
      n_checks++; if (almost_empty !== (i <= 1)) begin n_errors++; $display("FAIL midreset_bajo at %0d: got %0b", i, almost_empty); end
    end
  endtask

  task automatic test_random();
    reset = 1'b1; tick(1'b0, 1'b0, 6'h00); reset = 1'b0;
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 99) == 0);
      init = ($urandom_range(0, 19) == 0);
      umbral_alto = 4'($urandom_range(0, 10));
      umbral_bajo = 4'($urandom_range(0, 8));
      tick(1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 45), 6'($urandom));
      reset = 1'b0; init = 1'b0;
      n_checks++; if (count !== 4'(mq.size())) begin n_errors++; $display("FAIL rnd_count cyc %0d: got %0d expected %0d", n, count, mq.size()); end
      n_checks++;
      if ({empty, full, almost_full, almost_empty} !==
          {mq.size() == 0, mq.size() == 8, mq.size() >= m_alto, mq.size() <= m_bajo}) begin
        n_errors++; $display("FAIL rnd_flags cyc %0d: got %b%b%b%b (count %0d alto %0d bajo %0d)",
                             n, empty, full, almost_full, almost_empty, mq.size(), m_alto, m_bajo);
      end
      n_checks++; if ({valid_out, data_out} !== {m_valid, m_dout}) begin n_errors++; $display("FAIL rnd_read cyc %0d: got %0b/%0h expected %0b/%0h", n, valid_out, data_out, m_valid, m_dout); end
      n_checks++; if (error !== m_err) begin n_errors++; $display("FAIL rnd_error cyc %0d: got %0b expected %0b", n, error, m_err); end
    end
  endtask

  initial begin
    reset = 1'b1; init = 1'b0; push = 1'b0; pop = 1'b0; data_in = 6'h00;
    umbral_alto = 4'd0; umbral_bajo = 4'd0;
    test_reset();
    test_fill_drain();
    test_overflow();
    test_underflow_simul();
    test_full_push_pop();
    test_threshold_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fifo_buffer.md
# fifo_buffer

Parameterised synchronous FIFO for the router datapath: one instance per input port feeds the arbiter (via `empty`/`pop`), and one per output port absorbs the arbiter's `push` traffic while backpressuring through `almost_full`. Thresholds for `almost_full` and `almost_empty` are programmable during the system init phase and held afterwards. The block tracks occupancy, registers its read data and raises a sticky error on overflow/underflow attempts.

## Interface
- `DATA_WIDTH`, 6, word width (2-bit destination + 4-bit payload).
- `DEPTH`, 8, number of entries; power of two, ≥ 4.
- `ADDR_WIDTH`, 3, log2(DEPTH).
- `clk` input 1: single clock; all state updates on rising edge.
- `reset` input 1: synchronous, active-high.
- `init` input 1: high while the system FSM is in its INIT state; enables threshold loading.
- `umbral_alto` input ADDR_WIDTH+1: almost-full threshold, sampled while `init`=1.
- `umbral_bajo` input ADDR_WIDTH+1: almost-empty threshold, sampled while `init`=1.
- `push` input 1: write request.
- `data_in` input DATA_WIDTH: write data.
- `pop` input 1: read request.
- `data_out` output DATA_WIDTH: registered read data.
- `valid_out` output 1: `data_out` holds a word popped on the previous edge.
- `empty` output 1: count == 0.
- `full` output 1: count == DEPTH.
- `almost_full` output 1: count ≥ stored `umbral_alto`.
- `almost_empty` output 1: count ≤ stored `umbral_bajo`.
- `error` output 1: sticky overflow/underflow flag.
- `count` output ADDR_WIDTH+1: current occupancy.

## Operation
- Storage: DEPTH×DATA_WIDTH register array, write pointer `wr_ptr`, read pointer `rd_ptr` (ADDR_WIDTH bits each, wrap DEPTH-1 → 0 naturally), occupancy `count` (ADDR_WIDTH+1 bits, range 0..DEPTH).
- Reset (`reset`=1 at edge): `wr_ptr`=`rd_ptr`=0, `count`=0, `data_out`=0, `valid_out`=0, `error`=0, stored `umbral_alto`=DEPTH-1, stored `umbral_bajo`=1. Array contents don't care. Reset mid-operation discards all queued words; outputs read reset values the cycle after.
- Derived outputs after reset: `empty`=1, `full`=0, `almost_full`=0, `almost_empty`=1.
- Threshold load: each edge with `init`=1 and `reset`=0 stores `umbral_alto`/`umbral_bajo`; with `init`=0 stored values hold. Values > DEPTH are stored as-is (almost_full never asserts); no clamping.
- Write accepted when `push`=1 and (`full`=0 or pop accepted same edge): `mem[wr_ptr]`←`data_in`, `wr_ptr`+1.
- Read accepted when `pop`=1 and `empty`=0: `data_out`←`mem[rd_ptr]`, `rd_ptr`+1, `valid_out`←1. Otherwise `valid_out`←0 and `data_out` holds its last value.
- Count: +1 write only, −1 read only, unchanged for both or neither.
- Simultaneous push+pop when full: both accepted, count stays DEPTH.
- Simultaneous push+pop when empty: pop rejected, push accepted, count → 1; no read-through.
- Push rejected (full, no accepted pop): data dropped, `error`←1.
- Pop rejected (empty): `error`←1 regardless of `push`.
- `error` clears only on reset.
- `empty`, `full`, `almost_full`, `almost_empty` are combinational decodes of registered `count` and stored thresholds; no glitch-relevant paths from `push`/`pop`.

## Timing
- Write latency: word written at edge N is poppable at edge N+1 (`empty` deasserts after edge N).
- Read latency: pop sampled at edge N → `data_out`/`valid_out` valid after edge N, for exactly one cycle per accepted pop.
- Flag latency: flags reflect all push/pop accepted at edge N immediately after edge N; upstream must use `almost_full` (not `full`) to absorb its one-cycle reaction delay.
- Threshold change takes effect on flags the cycle after the loading edge.
- Back-to-back pops at one per cycle sustain full throughput; pointers wrap without bubbles.

## Test plan
- Reset: hold `reset`=1 two edges with `push`=`pop`=1 → `count`=0, `empty`=1, `almost_empty`=1, `valid_out`=0, `error`=0, `data_out`=0.
- Fill/drain: `init`=1 with `umbral_alto`=6, `umbral_bajo`=2 for one edge; push 0x01..0x08 → `almost_full` rises after 6th push, `full`=1 after 8th; pop 8 times → `data_out` 0x01..0x08 in order, `valid_out`=1 each cycle, `almost_empty` at count 2, `empty` at 0, `error`=0.
- Overflow: with count=8 push 0x3F alone → count stays 8, `error`=1, next pops return original data; `error` persists until reset.
- Underflow + simultaneous: empty FIFO, `push`=1 `data_in`=0x15 and `pop`=1 → count=1, `valid_out`=0, `error`=1; next pop → `data_out`=0x15.
- Full with push+pop: count=8, push 0x2A and pop same edge → count=8, `error`=0, popped word is oldest; 0x2A emerges after 8 further pops (pointer wrap).
- Threshold hold and mid-op reset: change `umbral_alto` to 2 with `init`=0 → flags unchanged; with count=5 assert `reset` one edge → count=0, thresholds back to 7/1.
